// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 single-precision divider: restoring radix-2 mantissa divide,
// round-to-nearest-even, flush-to-zero, fixed 29-cycle latency from the accepting edge.
module fdiv_seq #(
  parameter logic [31:0] NAN_VAL = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic [31:0] out_div,
  output logic        busy,
  output logic        done
);

  localparam int unsigned EXPW = 8;
  localparam int unsigned FW   = 23;
  localparam int unsigned MW   = FW + 1;
  localparam int unsigned QW   = 27;
  localparam int unsigned EW   = 10;
  localparam int unsigned CW   = 5;

  localparam logic [CW-1:0]          LAST_STEP = CW'(QW - 1);
  localparam logic [EXPW-1:0]        EXP_ONES  = '1;
  localparam logic signed [EW-1:0]   BIAS      = 10'sd127;
  localparam logic signed [EW-1:0]   BIAS_M1   = 10'sd126;
  localparam logic signed [EW-1:0]   EXP_ONE   = 10'sd1;
  localparam logic signed [EW-1:0]   EXP_MAX   = 10'sd255;
  localparam logic signed [EW-1:0]   EXP_ZERO  = 10'sd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [MW:0]          rem;
  logic [MW-1:0]        dvsr;
  logic [QW-1:0]        quo;
  logic                 sign;
  logic signed [EW-1:0] exp_diff;
  logic                 spec_hit;
  logic [31:0]          spec_val;

  // Operand classification on the live inputs, used only at the capture edge
  logic [EXPW-1:0] ea, eb;
  logic [FW-1:0]   fa, fb;
  logic            zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, sign_in;
  logic            spec_in;
  logic [31:0]     spec_res;
  logic            load;

  always_comb begin
    ea      = num1[30:23];
    eb      = num2[30:23];
    fa      = num1[22:0];
    fb      = num2[22:0];
    sign_in = num1[31] ^ num2[31];
    zero_a  = (ea == '0);
    zero_b  = (eb == '0);
    inf_a   = (ea == EXP_ONES) && (fa == '0);
    inf_b   = (eb == EXP_ONES) && (fb == '0);
    nan_a   = (ea == EXP_ONES) && (fa != '0);
    nan_b   = (eb == EXP_ONES) && (fb != '0);
    spec_in  = 1'b1;
    spec_res = '0;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b))
      spec_res = NAN_VAL;
    else if (inf_a)
      spec_res = {sign_in, EXP_ONES, {FW{1'b0}}};
    else if (inf_b)
      spec_res = {sign_in, {(EXPW + FW){1'b0}}};
    else if (zero_b)
      spec_res = {sign_in, EXP_ONES, {FW{1'b0}}};
    else if (zero_a)
      spec_res = {sign_in, {(EXPW + FW){1'b0}}};
    else
      spec_in = 1'b0;
  end

  assign load = start && ((state == IDLE) || (state == DONE));

  // One restoring step: trial subtract, keep the difference if it did not go negative
  logic [MW+1:0] diff;
  logic          qbit;
  logic [MW:0]   rem_sel;

  always_comb begin
    diff    = {1'b0, rem} - {2'b00, dvsr};
    qbit    = ~diff[MW+1];
    rem_sel = qbit ? diff[MW:0] : rem;
  end

  // Normalisation and round-to-nearest-even on the finished quotient
  logic [FW-1:0]        frac_pre;
  logic                 guard, sticky, inc;
  logic [MW-1:0]        frac_sum;
  logic                 carry;
  logic signed [EW-1:0] exp_pre, exp_r;
  logic [31:0]          result;

  always_comb begin
    if (quo[QW-1]) begin
      frac_pre = quo[25:3];
      guard    = quo[2];
      sticky   = (|quo[1:0]) | (|rem);
      exp_pre  = exp_diff + BIAS;
    end else begin
      frac_pre = quo[24:2];
      guard    = quo[1];
      sticky   = quo[0] | (|rem);
      exp_pre  = exp_diff + BIAS_M1;
    end
    inc      = guard & (sticky | frac_pre[0]);
    frac_sum = {1'b0, frac_pre} + MW'(inc);
    carry    = frac_sum[MW-1];
    exp_r    = carry ? exp_pre + EXP_ONE : exp_pre;
    if (spec_hit)
      result = spec_val;
    else if (exp_r >= EXP_MAX)
      result = {sign, EXP_ONES, {FW{1'b0}}};
    else if (exp_r <= EXP_ZERO)
      result = {sign, {(EXPW + FW){1'b0}}};
    else
      result = {sign, exp_r[EXPW-1:0], frac_sum[FW-1:0]};
  end

  // Control FSM with registered busy/done/out_div
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      out_div <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state <= DIVIDE;
        cnt   <= '0;
        busy  <= 1'b1;
      end else begin
        case (state)
          DIVIDE: begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST_STEP)
              state <= ROUND;
          end
          ROUND: begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            out_div <= result;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Operand capture and the quotient/remainder shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      dvsr     <= '0;
      quo      <= '0;
      sign     <= 1'b0;
      exp_diff <= '0;
      spec_hit <= 1'b0;
      spec_val <= '0;
    end else if (load) begin
      rem      <= zero_a ? '0 : {2'b01, fa};
      dvsr     <= zero_b ? '0 : {1'b1, fb};
      quo      <= '0;
      sign     <= sign_in;
      exp_diff <= $signed(EW'(ea) - EW'(eb));
      spec_hit <= spec_in;
      spec_val <= spec_res;
    end else if (state == DIVIDE) begin
      quo <= {quo[QW-2:0], qbit};
      rem <= rem_sel << 1;
    end
  end

endmodule
